// File: rtl/tff_bank_if.sv
// Control and status bundle for the tff_bank_counter block.
// The controller drives the operation request. The counter bank returns its
// registered state.
interface tff_bank_if #(
  parameter int WIDTH = 4
);
  logic             sclr;
  logic             load;
  logic [WIDTH-1:0] d;
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             ovf;

  modport master (
    output sclr, load, d, en, mode, t,
    input  q, tc, ovf
  );

  modport slave (
    input  sclr, load, d, en, mode, t,
    output q, tc, ovf
  );
endinterface

// File: rtl/tff_bank_counter.sv
// WIDTH-bit bank of T-type storage elements sharing one clock.
// The bank supports hold, per-bit toggle, count up and count down, plus
// parallel load and synchronous clear.
// The legal state range is 0..MAX. The counter either wraps at the terminal
// value or saturates there, selected by SAT.
// tc is a one-cycle pulse that marks a wrap, saturate or clamp on that update.
// ovf latches any tc until it is cleared by sclr or clr_n.
module tff_bank_counter #(
  parameter int WIDTH = 4,
  parameter int MAX   = 2**WIDTH - 1,
  parameter bit SAT   = 1'b0
) (
  input  logic       clk,
  input  logic       clr_n,
  tff_bank_if.slave  bus
);

  // Compares run one bit wider so a MAX at the top of the range never truncates.
  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX);
  localparam logic [WIDTH-1:0] MAX_Q   = MAX_EXT[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ZERO_Q  = '0;
  localparam logic [WIDTH-1:0] ONE_Q   = WIDTH'(1);

  typedef enum logic [1:0] {
    MODE_HOLD   = 2'b00,
    MODE_TOGGLE = 2'b01,
    MODE_UP     = 2'b10,
    MODE_DOWN   = 2'b11
  } mode_e;

  mode_e            mode_op;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] tgl;
  logic             tc_r;
  logic             tc_nxt;
  logic             ovf_r;
  logic             ovf_nxt;

  assign mode_op = mode_e'(bus.mode);

  // Next-state decode, with priority sclr > load > enabled mode > hold.
  // t and d are only looked at on the branch that uses them.
  always_comb begin
    q_nxt   = q_r;
    tc_nxt  = 1'b0;
    ovf_nxt = ovf_r;
    tgl     = ZERO_Q;
    if (bus.sclr) begin
      q_nxt   = ZERO_Q;
      ovf_nxt = 1'b0;
    end else begin
      if (bus.load) begin
        if ({1'b0, bus.d} > MAX_EXT) begin
          q_nxt  = MAX_Q;
          tc_nxt = 1'b1;
        end else begin
          q_nxt  = bus.d;
        end
      end else if (bus.en) begin
        case (mode_op)
          MODE_TOGGLE: begin
            tgl = q_r ^ bus.t;
            if ({1'b0, tgl} > MAX_EXT) begin
              q_nxt  = ZERO_Q;
              tc_nxt = 1'b1;
            end else begin
              q_nxt  = tgl;
            end
          end
          MODE_UP: begin
            if ({1'b0, q_r} < MAX_EXT) begin
              q_nxt = q_r + ONE_Q;
            end else begin
              q_nxt  = SAT ? MAX_Q : ZERO_Q;
              tc_nxt = 1'b1;
            end
          end
          MODE_DOWN: begin
            if (q_r != ZERO_Q) begin
              q_nxt = q_r - ONE_Q;
            end else begin
              q_nxt  = SAT ? ZERO_Q : MAX_Q;
              tc_nxt = 1'b1;
            end
          end
          default: begin
            q_nxt = q_r;
          end
        endcase
      end
      ovf_nxt = ovf_r | tc_nxt;
    end
  end

  // State register. clr_n clears all state at once, without waiting for a clock edge.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      q_r   <= ZERO_Q;
      tc_r  <= 1'b0;
      ovf_r <= 1'b0;
    end else begin
      q_r   <= q_nxt;
      tc_r  <= tc_nxt;
      ovf_r <= ovf_nxt;
    end
  end

  assign bus.q   = q_r;
  assign bus.tc  = tc_r;
  assign bus.ovf = ovf_r;

endmodule

// File: tb/tff_bank_counter_tb.sv
// Randomised and directed checks for tff_bank_counter.
// Three configurations are exercised in parallel against an arithmetic reference model:
//   - WIDTH=4, MAX=15, SAT=0
//   - WIDTH=4, MAX=9,  SAT=1
//   - WIDTH=4, MAX=9,  SAT=0
module tb_tff_bank_counter;
  logic clk = 1'b0;
  logic clr_n;

  always #5 clk = ~clk;

  tff_bank_if #(.WIDTH(4)) bus0 ();
  tff_bank_if #(.WIDTH(4)) bus1 ();
  tff_bank_if #(.WIDTH(4)) bus2 ();

  tff_bank_counter #(.WIDTH(4), .MAX(15), .SAT(1'b0)) u_dut0 (.clk(clk), .clr_n(clr_n), .bus(bus0));
  tff_bank_counter #(.WIDTH(4), .MAX(9),  .SAT(1'b1)) u_dut1 (.clk(clk), .clr_n(clr_n), .bus(bus1));
  tff_bank_counter #(.WIDTH(4), .MAX(9),  .SAT(1'b0)) u_dut2 (.clk(clk), .clr_n(clr_n), .bus(bus2));

  int n_vec = 0;
  int n_err = 0;

  int m_q[3]   = '{0, 0, 0};
  int m_tc[3]  = '{0, 0, 0};
  int m_ovf[3] = '{0, 0, 0};
  int m_max[3] = '{15, 9, 9};
  int m_sat[3] = '{0, 1, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: modulo arithmetic for wrap, min/max clamping for saturate.
  task automatic model_step(input int k, input bit sclr, input bit load, input int d,
                            input bit en, input int mode, input int t);
    int q;
    int mx;
    int tc;
    q  = m_q[k];
    mx = m_max[k];
    tc = 0;
    if (sclr) begin
      m_q[k] = 0; m_tc[k] = 0; m_ovf[k] = 0;
      return;
    end
    if (load) begin
      tc = (d > mx) ? 1 : 0;
      q  = (d > mx) ? mx : d;
    end else if (en) begin
      case (mode)
        1: begin
          q = q ^ t;
          if (q > mx) begin q = 0; tc = 1; end
        end
        2: begin
          tc = (q == mx) ? 1 : 0;
          q  = (m_sat[k] != 0) ? ((q < mx) ? q + 1 : mx) : (q + 1) % (mx + 1);
        end
        3: begin
          tc = (q == 0) ? 1 : 0;
          q  = (m_sat[k] != 0) ? ((q > 0) ? q - 1 : 0) : (q + mx) % (mx + 1);
        end
        default: ;
      endcase
    end
    m_q[k]  = q;
    m_tc[k] = tc;
    if (tc != 0) m_ovf[k] = 1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".q0"},   bus0.q,   m_q[0]);
    chk({tag, ".tc0"},  bus0.tc,  m_tc[0]);
    chk({tag, ".ovf0"}, bus0.ovf, m_ovf[0]);
    chk({tag, ".q1"},   bus1.q,   m_q[1]);
    chk({tag, ".tc1"},  bus1.tc,  m_tc[1]);
    chk({tag, ".ovf1"}, bus1.ovf, m_ovf[1]);
    chk({tag, ".q2"},   bus2.q,   m_q[2]);
    chk({tag, ".tc2"},  bus2.tc,  m_tc[2]);
    chk({tag, ".ovf2"}, bus2.ovf, m_ovf[2]);
  endtask

  task automatic drive_all(input bit sclr, input bit load, input int d,
                           input bit en, input int mode, input int t);
    bus0.sclr = sclr; bus0.load = load; bus0.d = 4'(d); bus0.en = en; bus0.mode = 2'(mode); bus0.t = 4'(t);
    bus1.sclr = sclr; bus1.load = load; bus1.d = 4'(d); bus1.en = en; bus1.mode = 2'(mode); bus1.t = 4'(t);
    bus2.sclr = sclr; bus2.load = load; bus2.d = 4'(d); bus2.en = en; bus2.mode = 2'(mode); bus2.t = 4'(t);
  endtask

  // One clocked update: drive on the falling edge, then check 1 ns after the rising edge.
  task automatic cycle(input bit sclr, input bit load, input int d, input bit en,
                       input int mode, input int t, input string tag);
    @(negedge clk);
    drive_all(sclr, load, d, en, mode, t);
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_step(k, sclr, load, d, en, mode, t);
    #1;
    check_all(tag);
  endtask

  // Mid-cycle clear pulse with no clock edge inside it.
  task automatic async_clear(input string tag);
    #2;
    clr_n = 1'b0;
    for (int k = 0; k < 3; k++) begin m_q[k] = 0; m_tc[k] = 0; m_ovf[k] = 0; end
    #1;
    check_all(tag);
    clr_n = 1'b1;
  endtask

  initial begin
    clr_n = 1'b0;
    drive_all(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    clr_n = 1'b1;

    // Count up from 0 through the wrap.
    for (int i = 1; i <= 17; i++) begin
      cycle(0, 0, 0, 1, 2, 0, "up");
      chk("up_q",   bus0.q,   i % 16);
      chk("up_tc",  bus0.tc,  (i == 16) ? 1 : 0);
      chk("up_ovf", bus0.ovf, (i >= 16) ? 1 : 0);
    end

    // Clear while ovf is set.
    async_clear("async1");
    chk("async1_q", bus0.q, 0);
    chk("async1_ovf", bus0.ovf, 0);

    // Saturate at 9, then wrap down from 0 to 9.
    cycle(0, 1, 8, 0, 0, 0, "ld8");
    cycle(0, 0, 0, 1, 2, 0, "sat1");
    chk("sat1_q", bus1.q, 9);  chk("sat1_tc", bus1.tc, 0);
    cycle(0, 0, 0, 1, 2, 0, "sat2");
    chk("sat2_q", bus1.q, 9);  chk("sat2_tc", bus1.tc, 1);
    cycle(0, 0, 0, 1, 2, 0, "sat3");
    chk("sat3_q", bus1.q, 9);  chk("sat3_tc", bus1.tc, 1);
    cycle(0, 1, 0, 0, 0, 0, "ld0");
    cycle(0, 0, 0, 1, 3, 0, "dnwrap");
    chk("dnwrap_q", bus2.q, 9); chk("dnwrap_tc", bus2.tc, 1);

    // Toggle cases.
    cycle(0, 1, 5, 0, 0, 0, "ld5");
    cycle(0, 0, 0, 1, 1, 3, "tgl");
    chk("tgl_q", bus0.q, 6);
    cycle(0, 1, 1, 0, 0, 0, "ld1");
    cycle(0, 0, 0, 1, 1, 10, "tglclamp");
    chk("tglclamp_q", bus2.q, 0); chk("tglclamp_tc", bus2.tc, 1);
    chk("tglnoclamp_q", bus0.q, 11);

    // Priority cases and load clamp.
    cycle(0, 1, 7, 1, 2, 0, "ldwins");
    chk("ldwins_q", bus0.q, 7);
    cycle(1, 1, 5, 1, 2, 0, "sclrwins");
    chk("sclrwins_q", bus2.q, 0); chk("sclrwins_ovf", bus2.ovf, 0);
    cycle(0, 1, 12, 0, 0, 0, "ldclamp");
    chk("ldclamp_q", bus1.q, 9); chk("ldclamp_tc", bus1.tc, 1);
    chk("ldnoclamp_q", bus0.q, 12);

    // Clear in the middle of a count, then resume counting.
    cycle(0, 1, 5, 0, 0, 0, "ld5b");
    cycle(0, 0, 0, 1, 2, 0, "up6");
    chk("up6_q", bus0.q, 6);
    async_clear("async2");
    chk("async2_q", bus0.q, 0);
    cycle(0, 0, 0, 1, 2, 0, "resume");
    chk("resume_q", bus0.q, 1);

    // Randomised traffic.
    for (int n = 0; n < 600; n++) begin
      cycle(($urandom_range(31) == 0), ($urandom_range(7) == 0), int'($urandom_range(15)),
            ($urandom_range(3) != 0), int'($urandom_range(3)), int'($urandom_range(15)), "rnd");
      if ($urandom_range(63) == 0) async_clear("rnd_async");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
